// File: rtl/vfifo_mc_fifo_sc.sv
// vfifo_mc_fifo_sc
// Single-clock multi-channel FIFO. NCH = 2**NCH_LOG2 logical FIFOs, each
// DEPTH = 2**ADDR_WIDTH deep, share one dual-port RAM addressed {channel, ptr}.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   wr_en, wr_ch, wr_data         write request into channel wr_ch
//   rd_en, rd_ch                  read request from channel rd_ch
//   rd_data, rd_valid, rd_valid_ch registered read result (1-cycle latency)
//   flush, flush_ch               clear one channel's pointers and count
//   empty, full                   per-channel flags (bit i = channel i)
//   fill                          packed per-channel counts, ADDR_WIDTH+1 bits each
//   wr_err, rd_err                one-cycle pulses for rejected write / read
module vfifo_mc_fifo_sc #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NCH_LOG2   = 2
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       wr_en,
  input  logic [NCH_LOG2-1:0]                        wr_ch,
  input  logic [DATA_WIDTH-1:0]                      wr_data,
  input  logic                                       rd_en,
  input  logic [NCH_LOG2-1:0]                        rd_ch,
  output logic [DATA_WIDTH-1:0]                      rd_data,
  output logic                                       rd_valid,
  output logic [NCH_LOG2-1:0]                        rd_valid_ch,
  input  logic                                       flush,
  input  logic [NCH_LOG2-1:0]                        flush_ch,
  output logic [(2**NCH_LOG2)-1:0]                   empty,
  output logic [(2**NCH_LOG2)-1:0]                   full,
  output logic [(2**NCH_LOG2)*(ADDR_WIDTH+1)-1:0]    fill,
  output logic                                       wr_err,
  output logic                                       rd_err
);

  localparam int NCH   = 2**NCH_LOG2;
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [NCH*DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q  [NCH];
  logic [ADDR_WIDTH-1:0] wptr_d  [NCH];
  logic [ADDR_WIDTH-1:0] rptr_q  [NCH];
  logic [ADDR_WIDTH-1:0] rptr_d  [NCH];
  logic [CW-1:0]         count_q [NCH];
  logic [CW-1:0]         count_d [NCH];
  logic [NCH-1:0]        empty_q, empty_d;
  logic [NCH-1:0]        full_q, full_d;

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [NCH_LOG2-1:0]   rd_valid_ch_q, rd_valid_ch_d;
  logic                  wr_err_q, wr_err_d;
  logic                  rd_err_q, rd_err_d;

  logic wr_flushed, rd_flushed;
  logic wr_ok, rd_ok;

  // Accept decisions use the registered flags; a flush on the same channel
  // silently drops the request (no error pulse).
  always_comb begin
    wr_flushed = flush && (flush_ch == wr_ch);
    rd_flushed = flush && (flush_ch == rd_ch);
    wr_ok      = wr_en && !full_q[wr_ch]  && !wr_flushed;
    rd_ok      = rd_en && !empty_q[rd_ch] && !rd_flushed;
    wr_err_d   = wr_en &&  full_q[wr_ch]  && !wr_flushed;
    rd_err_d   = rd_en &&  empty_q[rd_ch] && !rd_flushed;
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wptr_d[i]  = wptr_q[i];
      rptr_d[i]  = rptr_q[i];
      count_d[i] = count_q[i];
      if (wr_ok && (wr_ch == NCH_LOG2'(i))) wptr_d[i] = wptr_q[i] + 1'b1;
      if (rd_ok && (rd_ch == NCH_LOG2'(i))) rptr_d[i] = rptr_q[i] + 1'b1;
      if ((wr_ok && (wr_ch == NCH_LOG2'(i))) && !(rd_ok && (rd_ch == NCH_LOG2'(i))))
        count_d[i] = count_q[i] + 1'b1;
      else if (!(wr_ok && (wr_ch == NCH_LOG2'(i))) && (rd_ok && (rd_ch == NCH_LOG2'(i))))
        count_d[i] = count_q[i] - 1'b1;
      if (flush && (flush_ch == NCH_LOG2'(i))) begin
        wptr_d[i]  = '0;
        rptr_d[i]  = '0;
        count_d[i] = '0;
      end
      empty_d[i] = (count_d[i] == '0);
      full_d[i]  = (count_d[i] == CW'(DEPTH));
    end
  end

  // rd_data and rd_valid_ch hold their last values between accepted reads.
  always_comb begin
    rd_valid_d    = rd_ok;
    rd_data_d     = rd_data_q;
    rd_valid_ch_d = rd_valid_ch_q;
    if (rd_ok) begin
      rd_data_d     = mem[{rd_ch, rptr_q[rd_ch]}];
      rd_valid_ch_d = rd_ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        count_q[i] <= '0;
      end
      empty_q       <= '1;
      full_q        <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_valid_ch_q <= '0;
      wr_err_q      <= 1'b0;
      rd_err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        wptr_q[i]  <= wptr_d[i];
        rptr_q[i]  <= rptr_d[i];
        count_q[i] <= count_d[i];
      end
      empty_q       <= empty_d;
      full_q        <= full_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_valid_ch_q <= rd_valid_ch_d;
      wr_err_q      <= wr_err_d;
      rd_err_q      <= rd_err_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[{wr_ch, wptr_q[wr_ch]}] <= wr_data;
  end

  always_comb begin
    fill = '0;
    for (int i = 0; i < NCH; i++) fill[i*CW +: CW] = count_q[i];
  end

  assign empty       = empty_q;
  assign full        = full_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_valid_ch = rd_valid_ch_q;
  assign wr_err      = wr_err_q;
  assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_vfifo_mc_fifo_sc.sv
// Directed bench for vfifo_mc_fifo_sc with DEPTH 4, four channels, 8-bit data.
module tb_vfifo_mc_fifo_sc;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int CL = 2;
  localparam int NCH = 4;
  localparam int CW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en, flush;
  logic [CL-1:0] wr_ch, rd_ch, flush_ch;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [CL-1:0] rd_valid_ch;
  logic [NCH-1:0] empty, full;
  logic [NCH*CW-1:0] fill;
  logic          wr_err, rd_err;

  int n_checks = 0;
  int n_pass   = 0;

  vfifo_mc_fifo_sc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NCH_LOG2(CL)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .rd_en(rd_en), .rd_ch(rd_ch),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_valid_ch(rd_valid_ch),
    .flush(flush), .flush_ch(flush_ch),
    .empty(empty), .full(full), .fill(fill),
    .wr_err(wr_err), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  function automatic logic [CW-1:0] fill_of(input int ch);
    return fill[ch*CW +: CW];
  endfunction

  // Advance one clock; inputs settle and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'hF);
    check({tag, "_full"}, 32'(full), 32'h0);
    check({tag, "_fill"}, 32'(fill), 32'h0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
    check({tag, "_rd_valid_ch"}, 32'(rd_valid_ch), 32'h0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'h00);
    check({tag, "_errs"}, 32'({wr_err, rd_err}), 32'h0);
  endtask

  logic [DW-1:0] t2 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [DW-1:0] t3_exp [6] = '{8'hB0, 8'hA0, 8'hB1, 8'hA1, 8'hB2, 8'hA2};

  initial begin
    rst_n = 1'b0; idle();
    wr_ch = '0; rd_ch = '0; flush_ch = '0; wr_data = '0;

    // 1. reset and idle
    #12;
    check_reset_state("t1_in_reset");
    #10 rst_n = 1'b1;
    cyc(); cyc();
    check_reset_state("t1_idle");

    // 2. fill ch1, overflow, drain in order
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1; wr_ch = 2'd1; wr_data = t2[k];
      cyc();
    end
    wr_en = 1'b0;
    check("t2_full1", 32'(full[1]), 32'h1);
    check("t2_fill1", 32'(fill_of(1)), 32'h4);
    wr_en = 1'b1; wr_data = 8'h55;
    cyc();
    wr_en = 1'b0;
    check("t2_wr_err", 32'(wr_err), 32'h1);
    check("t2_fill1_after_ovf", 32'(fill_of(1)), 32'h4);
    cyc();
    check("t2_wr_err_pulse", 32'(wr_err), 32'h0);
    for (int k = 0; k < 4; k++) begin
      rd_en = 1'b1; rd_ch = 2'd1;
      cyc();
      rd_en = 1'b0;
      check("t2_rd_valid", 32'(rd_valid), 32'h1);
      check("t2_rd_data", 32'(rd_data), 32'(t2[k]));
      check("t2_rd_ch", 32'(rd_valid_ch), 32'h1);
    end
    check("t2_empty1", 32'(empty[1]), 32'h1);
    cyc();
    check("t2_rd_valid_drop", 32'(rd_valid), 32'h0);
    check("t2_rd_data_hold", 32'(rd_data), 32'h44);

    // 3. interleaved channels 0 and 3
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1; wr_ch = 2'd0; wr_data = 8'(8'hA0 + k); cyc();
      wr_ch = 2'd3; wr_data = 8'(8'hB0 + k); cyc();
    end
    wr_en = 1'b0;
    check("t3_fill0", 32'(fill_of(0)), 32'h3);
    check("t3_fill3", 32'(fill_of(3)), 32'h3);
    for (int k = 0; k < 6; k++) begin
      rd_en = 1'b1; rd_ch = (k % 2 == 0) ? 2'd3 : 2'd0;
      cyc();
      rd_en = 1'b0;
      check("t3_rd_data", 32'(rd_data), 32'(t3_exp[k]));
      check("t3_rd_ch", 32'(rd_valid_ch), (k % 2 == 0) ? 32'h3 : 32'h0);
    end
    check("t3_empty", 32'(empty), 32'hF);

    // 4. ch2 simultaneous read/write across pointer wrap
    wr_en = 1'b1; wr_ch = 2'd2;
    wr_data = 8'hC0; cyc();
    wr_data = 8'hC1; cyc();
    check("t4_fill2_pre", 32'(fill_of(2)), 32'h2);
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1; wr_ch = 2'd2; wr_data = 8'(8'hC2 + k);
      rd_en = 1'b1; rd_ch = 2'd2;
      cyc();
      check("t4_fill2", 32'(fill_of(2)), 32'h2);
      check("t4_rd_data", 32'(rd_data), 32'(8'hC0 + k));
    end
    wr_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rd_en = 1'b1; rd_ch = 2'd2; cyc();
      check("t4_tail", 32'(rd_data), 32'(8'hC6 + k));
    end
    rd_en = 1'b0;
    check("t4_empty2", 32'(empty[2]), 32'h1);

    // 5. read empty ch0 with same-cycle write (no bypass)
    rd_en = 1'b1; rd_ch = 2'd0;
    wr_en = 1'b1; wr_ch = 2'd0; wr_data = 8'h9C;
    cyc();
    idle();
    check("t5_rd_err", 32'(rd_err), 32'h1);
    check("t5_rd_valid", 32'(rd_valid), 32'h0);
    check("t5_rd_data_hold", 32'(rd_data), 32'hC7);
    check("t5_fill0", 32'(fill_of(0)), 32'h1);
    rd_en = 1'b1; rd_ch = 2'd0;
    cyc();
    rd_en = 1'b0;
    check("t5_rd_data", 32'(rd_data), 32'h9C);
    check("t5_rd_err_clear", 32'(rd_err), 32'h0);

    // 6. flush overrides write and read on ch1
    wr_en = 1'b1; wr_ch = 2'd1;
    for (int k = 0; k < 3; k++) begin
      wr_data = 8'(8'hD0 + k); cyc();
    end
    wr_en = 1'b0;
    wr_en = 1'b1; wr_ch = 2'd1; wr_data = 8'hEE;
    rd_en = 1'b1; rd_ch = 2'd1;
    wr_en = 1'b1; wr_ch = 2'd2; wr_data = 8'h77;
    flush = 1'b1; flush_ch = 2'd1;
    // Write to ch2 runs alongside the flush; the flushed ch1 read is dropped.
    cyc();
    idle();
    check("t6_fill1", 32'(fill_of(1)), 32'h0);
    check("t6_empty1", 32'(empty[1]), 32'h1);
    check("t6_rd_valid", 32'(rd_valid), 32'h0);
    check("t6_errs", 32'({wr_err, rd_err}), 32'h0);
    check("t6_fill2_other", 32'(fill_of(2)), 32'h1);
    wr_en = 1'b1; wr_ch = 2'd1; wr_data = 8'hEE; flush = 1'b1; flush_ch = 2'd1;
    cyc();
    idle();
    check("t6_flush_drops_wr", 32'(fill_of(1)), 32'h0);
    wr_en = 1'b1; wr_ch = 2'd1; wr_data = 8'hF0; cyc();
    wr_en = 1'b0; rd_en = 1'b1; rd_ch = 2'd1; cyc();
    rd_en = 1'b0;
    check("t6_post_flush_rd", 32'(rd_data), 32'hF0);

    // reset mid-stream with ch0 at fill 2 and a read just returned
    wr_en = 1'b1; wr_ch = 2'd0;
    wr_data = 8'h01; cyc();
    wr_data = 8'h02; cyc();
    wr_en = 1'b0;
    check("t6_fill0", 32'(fill_of(0)), 32'h2);
    rd_en = 1'b1; rd_ch = 2'd0;
    cyc();
    check("t6_pre_rst_valid", 32'(rd_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("t6_rst");
    idle();
    #3 rst_n = 1'b1;
    rd_en = 1'b1; rd_ch = 2'd0;
    cyc();
    rd_en = 1'b0;
    check("t6_after_rst_rd_err", 32'(rd_err), 32'h1);
    check("t6_after_rst_valid", 32'(rd_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
